// File: rtl/store_align_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_align_buffer
// Purpose  : Aligns SB/SH/SW store data into byte lanes with a byte mask, and
//            queues the stores for a valid/ready data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
module store_align_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_st_valid,
    output logic                       o_st_ready,
    input  logic [31:0]                i_st_addr,
    input  logic [31:0]                i_st_data,
    input  logic [2:0]                 i_funct3,
    output logic                       o_st_err,
    output logic                       o_dmem_valid,
    input  logic                       i_dmem_ready,
    output logic [31:0]                o_dmem_addr,
    output logic [31:0]                o_dmem_wdata,
    output logic [3:0]                 o_dmem_mask,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [29:0]         r_addr_mem [DEPTH];
    logic [31:0]         r_data_mem [DEPTH];
    logic [3:0]          r_mask_mem [DEPTH];

    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_count_nxt;
    logic                r_empty;
    logic                r_err;

    logic [1:0]          w_off;
    logic [31:0]         w_wdata;
    logic [3:0]          w_mask;
    logic                w_err;
    logic                w_accept;
    logic                w_enq;
    logic                w_deq;

    assign w_off = i_st_addr[1:0];

    always_comb begin
        w_wdata = '0;
        w_mask  = '0;
        w_err   = 1'b0;
        case (i_funct3)
            3'b000: begin
                w_wdata = {4{i_st_data[7:0]}};
                w_mask  = 4'b0001 << w_off;
            end
            3'b001: begin
                w_wdata = {2{i_st_data[15:0]}};
                w_mask  = w_off[1] ? 4'b1100 : 4'b0011;
                w_err   = w_off[0];
            end
            3'b010: begin
                w_wdata = i_st_data;
                w_mask  = 4'b1111;
                w_err   = (w_off != 2'b00);
            end
            default: w_err = 1'b1;
        endcase
    end

    // Readiness deliberately ignores a same-cycle dequeue.
    assign o_st_ready = (r_count != c_full);
    assign w_accept   = i_st_valid & o_st_ready;
    assign w_enq      = w_accept & ~w_err;
    assign w_deq      = o_dmem_valid & i_dmem_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_err   <= w_accept & w_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_addr_mem[r_wptr] <= i_st_addr[31:2];
            r_data_mem[r_wptr] <= w_wdata;
            r_mask_mem[r_wptr] <= w_mask;
        end
    end

    assign o_st_err     = r_err;
    assign o_count      = r_count;
    assign o_empty      = r_empty;
    assign o_dmem_valid = ~r_empty;
    assign o_dmem_addr  = r_empty ? 32'h0 : {r_addr_mem[r_rptr], 2'b00};
    assign o_dmem_wdata = r_empty ? 32'h0 : r_data_mem[r_rptr];
    assign o_dmem_mask  = r_empty ? 4'h0  : r_mask_mem[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_store_align_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_align_buffer
// Purpose  : Directed self-checking bench for store_align_buffer (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_align_buffer;

    localparam int DEPTH = 4;

    logic        i_clk;
    logic        i_rst;
    logic        i_st_valid;
    logic        o_st_ready;
    logic [31:0] i_st_addr;
    logic [31:0] i_st_data;
    logic [2:0]  i_funct3;
    logic        o_st_err;
    logic        o_dmem_valid;
    logic        i_dmem_ready;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic [2:0]  o_count;
    logic        o_empty;

    int n_checks;
    int n_errors;

    store_align_buffer #(.DEPTH(DEPTH)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_st_valid   (i_st_valid),
        .o_st_ready   (o_st_ready),
        .i_st_addr    (i_st_addr),
        .i_st_data    (i_st_data),
        .i_funct3     (i_funct3),
        .o_st_err     (o_st_err),
        .o_dmem_valid (o_dmem_valid),
        .i_dmem_ready (i_dmem_ready),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_mask  (o_dmem_mask),
        .o_count      (o_count),
        .o_empty      (o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One-cycle request; returns 1 ns after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        i_st_valid = 1'b1;
        i_st_addr  = addr;
        i_st_data  = data;
        i_funct3   = f3;
        tick();
        i_st_valid = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        i_rst        = 1'b0;
        i_st_valid   = 1'b0;
        i_st_addr    = '0;
        i_st_data    = '0;
        i_funct3     = '0;
        i_dmem_ready = 1'b1;
        #1 i_rst = 1'b1;
        #7;
        chk("rst_ready", 32'(o_st_ready), 32'd1);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_valid", 32'(o_dmem_valid), 32'd0);
        chk("rst_addr",  o_dmem_addr, 32'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);
        chk("rst_mask",  32'(o_dmem_mask), 32'h0);
        chk("rst_err",   32'(o_st_err), 32'd0);
        #4 i_rst = 1'b0;
        tick();

        // SB at offset 3
        send(32'h0000_1003, 32'h0000_00AB, 3'b000);
        chk("sb_valid", 32'(o_dmem_valid), 32'd1);
        chk("sb_addr",  o_dmem_addr, 32'h0000_1000);
        chk("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
        chk("sb_mask",  32'(o_dmem_mask), 32'h8);
        tick();
        chk("sb_drained", 32'(o_empty), 32'd1);

        // SH upper half, then misaligned SH
        send(32'h0000_2002, 32'h1234_BEEF, 3'b001);
        chk("sh_wdata", o_dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_mask",  32'(o_dmem_mask), 32'hC);
        chk("sh_err0",  32'(o_st_err), 32'd0);
        tick();
        send(32'h0000_2001, 32'h1234_BEEF, 3'b001);
        chk("sh_mis_err",   32'(o_st_err), 32'd1);
        chk("sh_mis_count", 32'(o_count), 32'd0);
        chk("sh_mis_valid", 32'(o_dmem_valid), 32'd0);
        tick();
        chk("sh_err_pulse", 32'(o_st_err), 32'd0);

        // Misaligned SW, illegal funct3, aligned SW
        send(32'h0000_3002, 32'hDEAD_BEEF, 3'b010);
        chk("sw_mis_err",   32'(o_st_err), 32'd1);
        chk("sw_mis_empty", 32'(o_empty), 32'd1);
        send(32'h0000_3000, 32'hDEAD_BEEF, 3'b011);
        chk("ill_err",   32'(o_st_err), 32'd1);
        chk("ill_empty", 32'(o_empty), 32'd1);
        send(32'h0000_3000, 32'hDEAD_BEEF, 3'b010);
        chk("sw_err0",  32'(o_st_err), 32'd0);
        chk("sw_addr",  o_dmem_addr, 32'h0000_3000);
        chk("sw_wdata", o_dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_mask",  32'(o_dmem_mask), 32'hF);
        tick();

        // Fill while memory stalls, then drain in order
        i_dmem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(32'h0000_4000 + 32'(4*i), 32'(i+1), 3'b010);
        chk("full_count", 32'(o_count), 32'(DEPTH));
        chk("full_ready", 32'(o_st_ready), 32'd0);
        send(32'h0000_4F00, 32'h0000_0055, 3'b010);
        chk("full_count_hold", 32'(o_count), 32'(DEPTH));
        chk("full_head_addr",  o_dmem_addr, 32'h0000_4000);
        chk("full_head_wdata", o_dmem_wdata, 32'h1);
        i_dmem_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_addr",  o_dmem_addr, 32'h0000_4000 + 32'(4*i));
            chk("drain_wdata", o_dmem_wdata, 32'(i+1));
            tick();
        end
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("drain_count", 32'(o_count), 32'd0);

        // Simultaneous enqueue and dequeue with one entry queued
        i_dmem_ready = 1'b0;
        send(32'h0000_5000, 32'h0000_000A, 3'b010);
        chk("sim_pre_count", 32'(o_count), 32'd1);
        i_dmem_ready = 1'b1;
        send(32'h0000_5004, 32'h0000_000B, 3'b010);
        chk("sim_count", 32'(o_count), 32'd1);
        chk("sim_addr",  o_dmem_addr, 32'h0000_5004);
        chk("sim_wdata", o_dmem_wdata, 32'hB);
        tick();
        chk("sim_empty", 32'(o_empty), 32'd1);

        // Stream well past 2*DEPTH entries to wrap both pointers
        for (int i = 0; i < 3*DEPTH; i++) begin
            send(32'h0000_6000 + 32'(4*i), 32'h100 + 32'(i), 3'b000);
            chk("wrap_count", 32'(o_count), 32'd1);
            chk("wrap_addr",  o_dmem_addr, 32'h0000_6000 + 32'(4*i));
            chk("wrap_wdata", o_dmem_wdata, {4{8'(i)}});
        end
        tick();
        chk("wrap_empty", 32'(o_empty), 32'd1);

        // Asynchronous reset with three entries queued
        i_dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h0000_7100 + 32'(4*i), 32'hEE + 32'(i), 3'b010);
        chk("pre_rst_count", 32'(o_count), 32'd3);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_dmem_valid), 32'd0);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_ready", 32'(o_st_ready), 32'd1);
        chk("arst_addr",  o_dmem_addr, 32'h0);
        tick();
        #2 i_rst = 1'b0;
        tick();
        send(32'h0000_7000, 32'h0000_0077, 3'b010);
        chk("post_rst_count", 32'(o_count), 32'd1);
        chk("post_rst_addr",  o_dmem_addr, 32'h0000_7000);
        chk("post_rst_wdata", o_dmem_wdata, 32'h77);
        i_dmem_ready = 1'b1;
        tick();
        chk("post_rst_empty", 32'(o_empty), 32'd1);
        chk("post_rst_valid", 32'(o_dmem_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
